// File: rtl/wdt_controller.sv
// Bus-programmable watchdog: keyed-kick down-counter that emits a one-cycle fault pulse
// with a cause code and the LOAD value in force when it expires or sees a bad key.
module wdt_controller #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [7:0]  CAUSE    = 8'h10,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned BUS_ACC_WIDTH = 2,
  parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = BUS_ACC_WIDTH'(1),
  parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = BUS_ACC_WIDTH'(2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     rdata,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic                     resp,
  output logic                     fault,
  output logic                     wdt_fault,
  output logic [7:0]               wdt_fault_cause,
  output logic [XLEN-1:0]          wdt_fault_addr
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StExpired = 2'd2;

  localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PscW-1:0] PscMax = PscW'(PRESCALE - 1);

  localparam logic [15:0] KickKey = 16'h5A5A;

  logic [1:0]           state_q, state_d;
  logic                 lock_q, lock_d;
  logic [XLEN-1:0]      load_q, load_d;
  logic [XLEN-1:0]      count_q, count_d;
  logic [PscW-1:0]      psc_q, psc_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 resp_q;
  logic                 wdt_fault_q;
  logic [XLEN-1:0]      fault_addr_q;

  logic is_ctrl, is_kick, is_load, is_count;
  logic size_ok, invld, acc_ok, wr, rd;
  logic ctrl_wr, kick_wr, good_key, tick, expire;

  // Address decode and access checking
  always_comb begin
    is_ctrl  = (addr == 4'd0);
    is_kick  = (addr == 4'd2);
    is_load  = (addr == 4'd4);
    is_count = (addr == 4'd8);
    size_ok  = ((is_ctrl | is_kick) & (acc == BUS_ACC_2B)) |
               ((is_load | is_count) & (acc == BUS_ACC_4B));
    invld    = ~size_ok |
               (is_kick & ~w_rb) |
               (is_count & w_rb) |
               ((is_ctrl | is_load) & w_rb & lock_q);
    acc_ok   = req & ~invld;
    wr       = acc_ok & w_rb;
    rd       = acc_ok & ~w_rb;
  end

  assign fault = req & invld;

  always_comb begin
    rdata_d = '0;
    if (is_ctrl) begin
      rdata_d = BUS_WIDTH'({lock_q, state_q != StIdle});
    end else if (is_load) begin
      rdata_d = BUS_WIDTH'(load_q);
    end else if (is_count) begin
      rdata_d = BUS_WIDTH'(count_q);
    end
  end

  // Next state: accepted writes take priority over the tick, so a good kick on the
  // expiring tick reloads instead of expiring.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    load_d   = load_q;
    count_d  = count_q;
    psc_d    = psc_q;
    expire   = 1'b0;
    ctrl_wr  = wr & is_ctrl & (state_q != StExpired);
    kick_wr  = wr & is_kick & (state_q == StRun);
    good_key = (wdata[15:0] == KickKey);
    tick     = (state_q == StRun) && (psc_q == PscMax);

    if (wr & is_load) load_d = XLEN'(wdata);
    if (ctrl_wr) lock_d = lock_q | wdata[1];
    if (state_q == StRun) psc_d = tick ? '0 : psc_q + 1'b1;

    if (ctrl_wr && wdata[0] && (state_q == StIdle)) begin
      state_d = StRun;
      count_d = load_q;
      psc_d   = '0;
    end else if (ctrl_wr && !wdata[0] && (state_q == StRun)) begin
      state_d = StIdle;
    end else if (kick_wr && good_key) begin
      count_d = load_q;
      psc_d   = '0;
    end else if (kick_wr || (tick && (count_q == '0))) begin
      state_d = StExpired;
      count_d = '0;
      expire  = 1'b1;
    end else if (tick) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lock_q       <= 1'b0;
      load_q       <= '1;
      count_q      <= '0;
      psc_q        <= '0;
      rdata_q      <= '0;
      resp_q       <= 1'b0;
      wdt_fault_q  <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      load_q      <= load_d;
      count_q     <= count_d;
      psc_q       <= psc_d;
      resp_q      <= acc_ok;
      wdt_fault_q <= expire;
      if (rd) rdata_q <= rdata_d;
      if (expire) fault_addr_q <= load_q;
    end
  end

  assign rdata           = rdata_q;
  assign resp            = resp_q;
  assign wdt_fault       = wdt_fault_q;
  assign wdt_fault_cause = CAUSE;
  assign wdt_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_wdt_controller.sv
// Randomized scoreboard bench for wdt_controller; expectations come from a timeline
// model (reload cycle, load value, prescale) rather than a cycle-by-cycle counter.
module tb_wdt_controller;

  localparam int P = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic        w_rb = 1'b0;
  logic [1:0]  acc = '0;
  logic [31:0] rdata;
  logic [31:0] wdata = '0;
  logic        req = 1'b0;
  logic        resp, fault, wdt_fault;
  logic [7:0]  cause;
  logic [31:0] faddr;

  wdt_controller #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .addr(addr), .w_rb(w_rb), .acc(acc), .rdata(rdata),
    .wdata(wdata), .req(req), .resp(resp), .fault(fault), .wdt_fault(wdt_fault),
    .wdt_fault_cause(cause), .wdt_fault_addr(faddr)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit          is_fault;
    bit          is_read;
    logic [3:0]  addr;
    logic [31:0] rdata;
  } exp_t;

  typedef enum int {MIdle, MRun, MExp} mst_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 0;
  longint      last_pulse = -1;

  mst_t        mst;
  bit          m_lock;
  logic [31:0] m_load;
  longint      m_r, m_l, m_exp, m_frozen;
  logic [31:0] snap1, snap2;

  // Load value in force during the previous cycle, for the fault address check.
  always @(posedge clk) begin
    snap1 <= m_load;
    snap2 <= snap1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    mst = MIdle; m_lock = 0; m_load = 32'hFFFF_FFFF; m_exp = -1; m_frozen = 0;
  endtask

  task automatic advance();
    if (mst == MRun && cyc >= m_exp) mst = MExp;
  endtask

  function automatic longint cur_count(input longint n);
    case (mst)
      MIdle:   return m_frozen;
      MRun:    return m_l - (n - m_r - 1) / P;
      default: return 0;
    endcase
  endfunction

  task automatic start_run(input longint n);
    m_r = n; m_l = longint'(m_load); m_exp = n + 1 + (m_l + 1) * P;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic [3:0] a, input bit w, input logic [1:0] s,
                     input logic [31:0] d);
    longint n;
    bit inv;
    exp_t e;
    n = cyc;
    advance();
    inv = !(a inside {4'd0, 4'd2, 4'd4, 4'd8}) ||
          ((a == 0 || a == 2) && s != 2'd1) || ((a == 4 || a == 8) && s != 2'd2) ||
          (a == 2 && !w) || (a == 8 && w) || (w && m_lock && (a == 0 || a == 4));
    e.is_fault = inv; e.is_read = !w; e.addr = a; e.rdata = '0;
    if (!inv && !w) begin
      if (a == 0) e.rdata = {30'b0, m_lock, mst != MIdle};
      else if (a == 4) e.rdata = m_load;
      else e.rdata = 32'(cur_count(n));
    end else if (!inv) begin
      if (a == 0 && mst != MExp) begin
        m_lock = m_lock | d[1];
        if (mst == MIdle && d[0]) begin
          mst = MRun; start_run(n);
        end else if (mst == MRun && !d[0]) begin
          m_frozen = cur_count(n); mst = MIdle; m_exp = -1;
        end
      end else if (a == 2 && mst == MRun) begin
        if (d[15:0] == 16'h5A5A) start_run(n);
        else begin mst = MExp; m_exp = n + 1; end
      end else if (a == 4) begin
        m_load = d;
      end
    end
    sb.push_back(e);
    addr = a; w_rb = w; acc = s; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    last_pulse = -1;
    rst = 1'b0;
    chk("rst_resp", resp, 0);
    chk("rst_wdt_fault", wdt_fault, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fault_addr", faddr, 0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (resp === 1'b1) begin
        if (sb.size() == 0) chk("resp_unexpected", resp, 0);
        else begin
          mon_e = sb.pop_front();
          chk($sformatf("outcome_resp_a%0d", mon_e.addr), mon_e.is_fault, 0);
          if (mon_e.is_read) chk($sformatf("rdata_a%0d", mon_e.addr), rdata, mon_e.rdata);
        end
      end
      if (fault === 1'b1) begin
        if (sb.size() == 0) chk("fault_unexpected", fault, 0);
        else begin
          mon_e = sb.pop_front();
          chk($sformatf("outcome_fault_a%0d", mon_e.addr), mon_e.is_fault, 1);
        end
      end
      chk("wdt_fault", wdt_fault, (cyc == m_exp));
      if (wdt_fault === 1'b1) begin
        last_pulse = cyc;
        if (cyc == m_exp) begin
          chk("fault_cause", cause, 8'h10);
          chk("fault_addr", faddr, snap2);
        end
      end
    end
  end

  initial begin
    longint n, e_cyc;
    logic [31:0] d;
    int r, op;
    model_reset();
    idle(2);
    rst = 1'b0;
    mon_en = 1;
    chk("init_resp", resp, 0);
    chk("init_wdt_fault", wdt_fault, 0);
    chk("init_fault_addr", faddr, 0);

    // Basic expiry with LOAD=3
    bus(4, 1, 2, 3);
    n = cyc;
    bus(0, 1, 1, 1);
    repeat (4 * P + 2) bus(8, 0, 2, 0);
    chk("basic_pulse_cycle", last_pulse, n + 1 + 4 * P);
    bus(0, 0, 1, 0);
    bus(2, 1, 1, 32'h5A5A);
    bus(8, 0, 2, 0);

    // Servicing
    do_reset();
    bus(4, 1, 2, 10);
    bus(0, 1, 1, 1);
    for (int k = 0; k < 100; k++) begin
      if (k % 8 == 0) bus(2, 1, 1, 32'h5A5A);
      else bus(8, 0, 2, 0);
    end
    chk("service_no_pulse", last_pulse, -1);

    // Bad key
    do_reset();
    bus(4, 1, 2, 20);
    bus(0, 1, 1, 1);
    idle(3);
    n = cyc;
    bus(2, 1, 1, 32'h1234);
    idle(1);
    chk("badkey_pulse_cycle", last_pulse, n + 1);
    bus(2, 1, 1, 32'h5A5A);
    bus(2, 1, 1, 32'h5A5A);
    bus(8, 0, 2, 0);
    bus(0, 0, 1, 0);
    bus(0, 1, 1, 0);
    bus(8, 0, 2, 0);

    // Lock
    do_reset();
    bus(4, 1, 2, 30);
    bus(0, 1, 1, 3);
    bus(0, 1, 1, 0);
    bus(4, 1, 2, 7);
    bus(8, 0, 2, 0);
    bus(0, 0, 1, 0);
    bus(4, 0, 2, 0);
    idle(2);
    bus(8, 0, 2, 0);

    // Bus faults
    do_reset();
    bus(2, 0, 1, 0);
    bus(0, 0, 2, 0);
    bus(6, 0, 1, 0);
    bus(8, 1, 2, 5);
    bus(0, 1, 2, 1);
    bus(8, 0, 2, 0);
    bus(0, 0, 1, 0);
    bus(4, 0, 2, 0);

    // Good kick on the expiring tick, then reset mid-RUN
    do_reset();
    bus(4, 1, 2, 2);
    n = cyc;
    bus(0, 1, 1, 1);
    e_cyc = n + 1 + 3 * P;
    while (cyc < e_cyc - 1) idle(1);
    bus(2, 1, 1, 32'h5A5A);
    bus(8, 0, 2, 0);
    chk("race_no_pulse", last_pulse, -1);
    idle(2);
    do_reset();
    bus(0, 0, 1, 0);
    bus(8, 0, 2, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      advance();
      r = $urandom_range(0, 99);
      if ((mst == MExp && r < 30) || (m_lock && r < 8)) begin
        do_reset();
      end else begin
        op = $urandom_range(0, 15);
        case (op)
          0, 1:     bus(0, 0, 1, 0);
          2:        bus(4, 0, 2, 0);
          3, 4, 5:  bus(8, 0, 2, 0);
          6, 7: begin
            d = 32'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) d[1] = 1'b1;
            bus(0, 1, 1, d);
          end
          8, 9:     bus(4, 1, 2, 32'($urandom_range(0, 12)));
          10, 11, 12: begin
            d = $urandom;
            d[15:0] = 16'h5A5A;
            bus(2, 1, 1, d);
          end
          13: begin
            if ($urandom_range(0, 2) == 0) bus(2, 1, 1, $urandom);
            else bus(8, 0, 2, 0);
          end
          14: bus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)));
          default: idle($urandom_range(1, 6));
        endcase
      end
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
